// File: rtl/user_lock_pkg.sv
// Shared types and defaults for the user-locked register read and write paths.
package user_lock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ID_W     = 2;
    // Must match the authorised ID of the write-side register.
    localparam int DEF_READ_ID  = 2;
    localparam int DEF_MAX_VIOL = 3;
    localparam int AUDIT_LIMIT  = 255;

endpackage

// File: rtl/user_lock_viol_ctr.sv
// Saturating up-counter with a terminal-count flag (hit = cnt==LIMIT).
module user_lock_viol_ctr #(
    parameter int LIMIT = 3,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_hit
);

    localparam logic [W-1:0] LIM_V = W'(LIMIT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIM_V)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_hit = (r_cnt == LIM_V);

endmodule

// File: rtl/user_locked_reader.sv
// Read responder for a user-locked register with sticky lockout after repeated violations.
// Optional audit outputs (audit_id, audit_cnt) are enabled by USER_LOCKED_READER_AUDIT_EN.
//
// state  | meaning
// IDLE   | granting; next rd_req is captured and checked
// RESP   | response held on rsp_* until rsp_ready
// LOCKED | violation limit reached; port dead until reset
module user_locked_reader
    import user_lock_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ID_W     = DEF_ID_W,
    parameter int READ_ID  = DEF_READ_ID,
    parameter int MAX_VIOL = DEF_MAX_VIOL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ID_W-1:0]   rd_usr_id,
    output logic              rd_gnt,
    input  logic [DATA_W-1:0] reg_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              locked
`ifdef USER_LOCKED_READER_AUDIT_EN
    ,
    output logic [ID_W-1:0]   audit_id,
    output logic [7:0]        audit_cnt
`endif
);

    localparam int VW = $clog2(MAX_VIOL + 1);
    localparam logic [ID_W-1:0] READ_ID_V = ID_W'(READ_ID);

    state_t            r_state;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic              w_id_ok;
    logic              w_viol_inc;
    logic              w_viol_hit;
    logic [VW-1:0]     w_viol_cnt_unused;

    assign w_id_ok    = (rd_usr_id == READ_ID_V);
    assign w_viol_inc = (r_state == IDLE) && rd_req && !w_id_ok;

    user_lock_viol_ctr #(
        .LIMIT (MAX_VIOL),
        .W     (VW)
    ) u_viol_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_viol_inc),
        .o_cnt (w_viol_cnt_unused),
        .o_hit (w_viol_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rd_req) begin
                        r_state    <= RESP;
                        r_rsp_data <= w_id_ok ? reg_data : '0;
                        r_rsp_err  <= !w_id_ok;
                    end
                end
                RESP: begin
                    // Counter already reflects this request's violation here.
                    if (rsp_ready) begin
                        r_state    <= w_viol_hit ? LOCKED : IDLE;
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b0;
                    end
                end
                LOCKED: begin
                    r_state <= LOCKED;
                end
                default: begin
                    r_state    <= IDLE;
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_gnt    = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign locked    = (r_state == LOCKED);
    // Gate so register bits can never appear outside a live response.
    assign rsp_data  = rsp_valid ? r_rsp_data : '0;
    assign rsp_err   = rsp_valid & r_rsp_err;

`ifdef USER_LOCKED_READER_AUDIT_EN
    logic            w_aud_inc;
    logic            w_aud_sat_unused;
    logic [7:0]      w_aud_cnt;
    logic [ID_W-1:0] r_audit_id;

    // Attempts while LOCKED still count as violations for audit purposes.
    assign w_aud_inc = rd_req && !w_id_ok && ((r_state == IDLE) || (r_state == LOCKED));

    user_lock_viol_ctr #(
        .LIMIT (AUDIT_LIMIT),
        .W     (8)
    ) u_audit_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_aud_inc),
        .o_cnt (w_aud_cnt),
        .o_hit (w_aud_sat_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_audit_id <= '0;
        end else if (w_aud_inc) begin
            r_audit_id <= rd_usr_id;
        end
    end

    assign audit_id  = r_audit_id;
    assign audit_cnt = w_aud_cnt;
`endif

endmodule

// File: tb/tb_user_locked_reader.sv
// Directed bench for user_locked_reader; audit checks compile in with USER_LOCKED_READER_AUDIT_EN.
module tb_user_locked_reader;

    logic       clk;
    logic       rst_n;
    logic       rd_req;
    logic [1:0] rd_usr_id;
    logic       rd_gnt;
    logic [7:0] reg_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       locked;
`ifdef USER_LOCKED_READER_AUDIT_EN
    logic [1:0] audit_id;
    logic [7:0] audit_cnt;
`endif

    int checks;
    int failures;

    user_locked_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_req    (rd_req),
        .rd_usr_id (rd_usr_id),
        .rd_gnt    (rd_gnt),
        .reg_data  (reg_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .locked    (locked)
`ifdef USER_LOCKED_READER_AUDIT_EN
        ,
        .audit_id  (audit_id),
        .audit_cnt (audit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one grant cycle; returns at the negedge of the response cycle.
    task automatic issue(input logic [1:0] id, input logic [7:0] d);
        @(negedge clk);
        rd_req    = 1'b1;
        rd_usr_id = id;
        reg_data  = d;
        @(posedge clk);
        #1;
        rd_req    = 1'b0;
        rd_usr_id = 2'd0;
        @(negedge clk);
    endtask

    task automatic complete();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if ({rd_gnt, rsp_valid, rsp_data, rsp_err, locked} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b vld=%b data=%h err=%b lck=%b want 1 0 00 0 0",
                     rd_gnt, rsp_valid, rsp_data, rsp_err, locked);
        end
    endtask

    task automatic test_auth_read();
        rsp_ready = 1'b1;
        issue(2'd2, 8'hA5);
        reg_data = 8'h00;
        checks++;
        if ({rsp_valid, rsp_data, rsp_err, rd_gnt} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL auth_resp got vld=%b data=%h err=%b gnt=%b want 1 a5 0 0",
                     rsp_valid, rsp_data, rsp_err, rd_gnt);
        end
        complete();
        checks++;
        if ({rsp_valid, rsp_data, rd_gnt, locked} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL auth_idle got vld=%b data=%h gnt=%b lck=%b want 0 00 1 0",
                     rsp_valid, rsp_data, rd_gnt, locked);
        end
    endtask

    task automatic test_unauth_read();
        issue(2'd1, 8'hFF);
        checks++;
        if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL unauth_resp got vld=%b data=%h err=%b want 1 00 1",
                     rsp_valid, rsp_data, rsp_err);
        end
        complete();
        checks++;
        if ({locked, rd_gnt, rsp_err} !== {1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL unauth_after got lck=%b gnt=%b err=%b want 0 1 0", locked, rd_gnt, rsp_err);
        end
    endtask

    task automatic test_stall();
        rsp_ready = 1'b0;
        issue(2'd2, 8'h11);
        reg_data = 8'h22;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, rsp_data, rsp_err, rd_gnt} !== {1'b1, 8'h11, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold[%0d] got vld=%b data=%h err=%b gnt=%b want 1 11 0 0",
                         i, rsp_valid, rsp_data, rsp_err, rd_gnt);
            end
            @(negedge clk);
        end
        complete();
        checks++;
        if ({rsp_valid, rd_gnt, rsp_data} !== {1'b0, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL stall_release got vld=%b gnt=%b data=%h want 0 1 00", rsp_valid, rd_gnt, rsp_data);
        end
    endtask

    // Authorised read between violations must not clear the sticky count.
    task automatic test_lockout();
        pulse_reset();
        rsp_ready = 1'b1;
        issue(2'd0, 8'h5C);
        complete();
        issue(2'd2, 8'h3C);
        checks++;
        if ({rsp_data, rsp_err} !== {8'h3C, 1'b0}) begin
            failures++;
            $display("FAIL lock_auth_mid got data=%h err=%b want 3c 0", rsp_data, rsp_err);
        end
        complete();
        issue(2'd1, 8'h77);
        complete();
        checks++;
        if ({locked, rd_gnt} !== {1'b0, 1'b1}) begin
            failures++;
            $display("FAIL lock_after_two got lck=%b gnt=%b want 0 1", locked, rd_gnt);
        end
        rsp_ready = 1'b0;
        issue(2'd3, 8'h99);
        checks++;
        if ({rsp_valid, rsp_data, rsp_err, locked} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL lock_third_resp got vld=%b data=%h err=%b lck=%b want 1 00 1 0",
                     rsp_valid, rsp_data, rsp_err, locked);
        end
        complete();
        checks++;
        if ({locked, rd_gnt, rsp_valid} !== {1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL lock_engaged got lck=%b gnt=%b vld=%b want 1 0 0", locked, rd_gnt, rsp_valid);
        end
        rd_req    = 1'b1;
        rd_usr_id = 2'd2;
        reg_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({rd_gnt, rsp_valid, rsp_data, locked} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
                failures++;
                $display("FAIL lock_ignore[%0d] got gnt=%b vld=%b data=%h lck=%b want 0 0 00 1",
                         i, rd_gnt, rsp_valid, rsp_data, locked);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_reset_locked();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, rd_gnt, rsp_valid, rsp_data, rsp_err} !== {1'b0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL rst_locked got lck=%b gnt=%b vld=%b data=%h err=%b want 0 1 0 00 0",
                     locked, rd_gnt, rsp_valid, rsp_data, rsp_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_resp();
        rsp_ready = 1'b0;
        issue(2'd2, 8'h77);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_data, rsp_err, rd_gnt, locked} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_resp got vld=%b data=%h err=%b gnt=%b lck=%b want 0 00 0 1 0",
                     rsp_valid, rsp_data, rsp_err, rd_gnt, locked);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b0, 8'h00}) begin
            failures++;
            $display("FAIL rst_no_stale got vld=%b data=%h want 0 00", rsp_valid, rsp_data);
        end
        issue(2'd2, 8'h5A);
        checks++;
        if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 8'h5A, 1'b0}) begin
            failures++;
            $display("FAIL rst_then_read got vld=%b data=%h err=%b want 1 5a 0", rsp_valid, rsp_data, rsp_err);
        end
        complete();
    endtask

`ifdef USER_LOCKED_READER_AUDIT_EN
    task automatic test_audit();
        pulse_reset();
        rsp_ready = 1'b1;
        issue(2'd3, 8'h01);
        complete();
        issue(2'd1, 8'h02);
        complete();
        checks++;
        if ({audit_id, audit_cnt} !== {2'd1, 8'd2}) begin
            failures++;
            $display("FAIL audit_two got id=%0d cnt=%0d want 1 2", audit_id, audit_cnt);
        end
        issue(2'd0, 8'h03);
        complete();
        @(negedge clk);
        rd_req    = 1'b1;
        rd_usr_id = 2'd0;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({audit_id, audit_cnt, locked} !== {2'd0, 8'd4, 1'b1}) begin
            failures++;
            $display("FAIL audit_locked got id=%0d cnt=%0d lck=%b want 0 4 1", audit_id, audit_cnt, locked);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        rd_req    = 1'b0;
        rd_usr_id = 2'd0;
        reg_data  = 8'h00;
        rsp_ready = 1'b0;
        #3;
        test_reset();
        #19;
        rst_n = 1'b1;
        test_auth_read();
        test_unauth_read();
        test_stall();
        test_lockout();
        test_reset_locked();
        test_reset_resp();
`ifdef USER_LOCKED_READER_AUDIT_EN
        test_audit();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
